// File: rtl/bit_serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice and one carry flip-flop reused for WIDTH cycles.
// Define BIT_SERIAL_ADDER_SUB_EN to add a "sub" input that turns the block into an a-b subtractor.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef BIT_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             load;
    logic             last;
    logic             bit_s;
    logic             bit_c;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Subtraction is a + ~b + 1, so only the B operand and the initial carry change.
`ifdef BIT_SERIAL_ADDER_SUB_EN
    always_comb begin
        b_load = sub ? ~b : b;
        c_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load = b;
        c_load = cin;
    end
`endif

    // Start is honoured in IDLE and DONE; while running it is simply dropped.
    assign load  = start && (state != RUN);
    assign last  = (state == RUN) && (cnt == CW'(WIDTH - 1));

    assign bit_s = a_sh[0] ^ b_sh[0] ^ carry;
    assign bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = load ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let a_sh shift before bit_s is computed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b_load;
            s_sh  <= '0;
            carry <= c_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            s_sh  <= {bit_s, s_sh[WIDTH-1:1]};
            carry <= bit_c;
            cnt   <= cnt + 1'b1;
            // The result registers only move on the final bit, so the previous answer stays visible.
            if (last) begin
                sum  <= {bit_s, s_sh[WIDTH-1:1]};
                cout <= bit_c;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder (WIDTH=8); sub tests build when
// BIT_SERIAL_ADDER_SUB_EN is defined.
module tb_bit_serial_adder;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 30;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int compared;
    int mismatched;

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef BIT_SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one cycle, then wait (bounded) for done. Returns at the negedge
    // where done is high, with lat = cycles since the accepting edge.
    task automatic do_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic ci,
                         output int lat, output int busy_cycles);
        @(negedge clk);
        a = ai; b = bi; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cycles = 0;
        while (!done && lat < TIMEOUT) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        compared++;
        if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({busy, done} !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        int lat, bc;
        do_op(8'h5A, 8'h3C, 1'b0, lat, bc);
        compared++;
        if (lat !== 9) begin
            mismatched++;
            $display("FAIL basic_latency: %0d cycles, required 9", lat);
        end
        compared++;
        if (bc !== 8) begin
            mismatched++;
            $display("FAIL basic_busy_cycles: %0d, required 8", bc);
        end
        compared++;
        if ({cout, sum} !== 9'h096) begin
            mismatched++;
            $display("FAIL basic_sum: cout=%b sum=%h, required cout=0 sum=96", cout, sum);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_done_one_cycle: done=%b, required 0", done);
        end
    endtask

    task automatic test_carry;
        int lat, bc;
        do_op(8'hFF, 8'h01, 1'b0, lat, bc);
        compared++;
        if ({cout, sum} !== 9'h100 || lat !== 9) begin
            mismatched++;
            $display("FAIL carry_ff_01: cout=%b sum=%h lat=%0d, required cout=1 sum=00 lat=9", cout, sum, lat);
        end
        do_op(8'hFF, 8'hFF, 1'b1, lat, bc);
        compared++;
        if ({cout, sum} !== 9'h1FF || lat !== 9) begin
            mismatched++;
            $display("FAIL carry_ff_ff_1: cout=%b sum=%h lat=%0d, required cout=1 sum=FF lat=9", cout, sum, lat);
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (2) begin @(negedge clk); lat++; end
        // Previous result (FF, cout 1) must still be visible mid-run.
        compared++;
        if ({cout, sum} !== 9'h1FF || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL hold_prev_result: busy=%b cout=%b sum=%h, required busy=1 cout=1 sum=FF", busy, cout, sum);
        end
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        @(negedge clk); lat++;
        start = 1'b0;
        while (!done && lat < TIMEOUT) begin @(negedge clk); lat++; end
        compared++;
        if ({cout, sum} !== 9'h030 || lat !== 9) begin
            mismatched++;
            $display("FAIL ignore_start: cout=%b sum=%h lat=%0d, required cout=0 sum=30 lat=9", cout, sum, lat);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL ignore_start_no_queue: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat, bc, seen;
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        compared++;
        if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b, required all 0", busy, done, sum, cout);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL reset_abandon: %0d busy/done cycles after reset, required 0", seen);
        end
        do_op(8'h12, 8'h34, 1'b1, lat, bc);
        compared++;
        if ({cout, sum} !== 9'h047 || lat !== 9) begin
            mismatched++;
            $display("FAIL after_reset_op: cout=%b sum=%h lat=%0d, required cout=0 sum=47 lat=9", cout, sum, lat);
        end
    endtask

    task automatic test_back_to_back;
        int done_at[$];
        int bad_busy;
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        bad_busy = 0;
        for (int n = 1; n <= 27; n++) begin
            @(negedge clk);
            if (busy !== !done) bad_busy++;
            if (done) begin
                done_at.push_back(n);
                compared++;
                if ({cout, sum} !== 9'h002) begin
                    mismatched++;
                    $display("FAIL b2b_sum: cycle %0d cout=%b sum=%h, required cout=0 sum=02", n, cout, sum);
                end
            end
        end
        start = 1'b0;
        compared++;
        if (bad_busy !== 0) begin
            mismatched++;
            $display("FAIL b2b_busy: %0d cycles with busy==done, required 0", bad_busy);
        end
        compared++;
        if (done_at.size() !== 3 || done_at[0] !== 9 || done_at[1] !== 18 || done_at[2] !== 27) begin
            mismatched++;
            $display("FAIL b2b_done_spacing: %0d pulses, first at %0d, required 3 pulses at 9/18/27",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1);
        end
        repeat (2) @(negedge clk);
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_return_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

`ifdef BIT_SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int lat, bc;
        sub = 1'b1;
        do_op(8'h05, 8'h07, 1'b0, lat, bc);
        compared++;
        if ({cout, sum} !== 9'h0FE) begin
            mismatched++;
            $display("FAIL sub_borrow: cout=%b sum=%h, required cout=0 sum=FE", cout, sum);
        end
        do_op(8'h07, 8'h05, 1'b0, lat, bc);
        compared++;
        if ({cout, sum} !== 9'h102) begin
            mismatched++;
            $display("FAIL sub_no_borrow: cout=%b sum=%h, required cout=1 sum=02", cout, sum);
        end
        sub = 1'b0;
    endtask
`endif

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
`ifdef BIT_SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
